// File: rtl/uart_pkg.sv
// Shared types, constants and timing helpers for the buffered UART transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

    localparam int unsigned FRAME_DATA_BITS = 8;
    localparam logic        START_BIT       = 1'b0;
    localparam logic        STOP_BIT        = 1'b1;

    // Clock cycles per serial bit (integer division, remainder dropped)
    function automatic int unsigned symbol_edge_time(input int unsigned clock_freq,
                                                     input int unsigned baud_rate);
        return clock_freq / baud_rate;
    endfunction

    function automatic int unsigned baud_cnt_width(input int unsigned set);
        return $clog2(set) + 1;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Small first-word-fall-through byte FIFO with occupancy counter and wrapping pointers.
module uart_tx_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    // Storage needs no reset: entries are only read once written
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: FIFO front end plus 8N1 serialiser on SOut.
// Optional even parity bit when UART_TX_PARITY_EN is defined.
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int unsigned CLOCK_FREQ = 50_000_000,
    parameter int unsigned BAUD_RATE  = 115_200,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic [7:0] DataIn,
    input  logic       DataInValid,
    output logic       DataInReady,
    output logic       SOut,
    output logic       TxBusy
);

    localparam int unsigned SET = symbol_edge_time(CLOCK_FREQ, BAUD_RATE);
    localparam int unsigned CW  = baud_cnt_width(SET);
    localparam int unsigned BW  = $clog2(FRAME_DATA_BITS);
    localparam logic [CW-1:0] BAUD_RELOAD = CW'(SET - 1);
    localparam logic [BW-1:0] LAST_BIT    = BW'(FRAME_DATA_BITS - 1);

    tx_state_e            state_q, state_d;
    logic [CW-1:0]        baud_q, baud_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [7:0]           shift_q, shift_d;
    logic                 sout_q, sout_d;
    logic                 baud_done;
    logic                 start_frame;
    logic                 fifo_push;
    logic                 fifo_pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [7:0]           fifo_dout;
`ifdef UART_TX_PARITY_EN
    logic                 parity_q, parity_d;
`endif

    assign DataInReady = ~fifo_full;
    assign fifo_push   = DataInValid & ~fifo_full;
    assign TxBusy      = (state_q != IDLE) | ~fifo_empty;
    assign SOut        = sout_q;
    assign baud_done   = (baud_q == '0);

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (CLK),
        .rst_n (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (DataIn),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Next-state, baud/bit counters and the registered line value
    always_comb begin
        state_d     = state_q;
        baud_d      = baud_done ? baud_q : baud_q - CW'(1);
        bit_d       = bit_q;
        shift_d     = shift_q;
        start_frame = 1'b0;
        fifo_pop    = 1'b0;
        sout_d      = STOP_BIT;
`ifdef UART_TX_PARITY_EN
        parity_d    = parity_q;
`endif

        case (state_q)
            IDLE: begin
                start_frame = ~fifo_empty;
            end
            START: begin
                if (baud_done) begin
                    baud_d  = BAUD_RELOAD;
                    bit_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (baud_done) begin
                    baud_d  = BAUD_RELOAD;
                    shift_d = shift_q >> 1;
                    if (bit_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_d = bit_q + BW'(1);
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (baud_done) begin
                    baud_d  = BAUD_RELOAD;
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (baud_done) begin
                    state_d     = IDLE;
                    start_frame = ~fifo_empty;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Shared by IDLE and end-of-stop so frames can run back to back
        if (start_frame) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_dout;
            baud_d   = BAUD_RELOAD;
            state_d  = START;
`ifdef UART_TX_PARITY_EN
            parity_d = ^fifo_dout;
`endif
        end

        case (state_d)
            START:   sout_d = START_BIT;
            DATA:    sout_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  sout_d = parity_d;
`endif
            default: sout_d = STOP_BIT;
        endcase
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            sout_q   <= STOP_BIT;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            sout_q   <= sout_d;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

endmodule
